tree_router_node: RTL and testbench
===================================

Name: tree_router_node

Overview:
- Parametrised clocked successor of the three-way tree router node.
- Routes single-flit packets between one parent port and NUM_CHILD child ports of a fat-tree NoC level.
- Each input has a small FIFO; each output has a round-robin arbiter and a registered output stage.
- Adds address-prefix routing at any tree level, U-turn and misroute detection, and per-port valid/ready backpressure.

Parameters:
- NUM_CHILD, 2, number of child ports (>=2); port 0 = parent, ports 1..NUM_CHILD = children.
- DATA_W, 16, flit width; destination address = flit[ADDR_W-1:0].
- ADDR_W, 6, destination address width; must be >= (LEVEL+1)*CB, where CB = clog2(NUM_CHILD).
- LEVEL, 0, tree depth of this node (root = 0).
- NODE_PREFIX, 0, the LEVEL*CB address bits identifying this node's subtree; ignored when LEVEL=0.
- FIFO_DEPTH, 2, entries per input FIFO (power of two, >=2).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_data  in  (NUM_CHILD+1)*DATA_W  input flits; port p at slice [p*DATA_W +: DATA_W].
- in_valid  in  NUM_CHILD+1  input valid per port.
- in_ready  out  NUM_CHILD+1  input ready per port; high when that port's FIFO is not full.
- out_data  out  (NUM_CHILD+1)*DATA_W  output flits.
- out_valid  out  NUM_CHILD+1  output valid per port.
- out_ready  in  NUM_CHILD+1  downstream ready per port.
- err_uturn  out  NUM_CHILD+1  one-cycle pulse: head flit on port p dropped because it routed back to p.
- err_misroute  out  1  one-cycle pulse: parent-port head dropped because of a prefix mismatch.

Behaviour:
- Handshake: a transfer occurs on a cycle with valid & ready high. Once valid is asserted, the sender holds data stable until ready.
- Reset:
  - FIFOs empty, output registers empty, arbiter pointers = 0.
  - All out_valid, err_uturn and err_misroute = 0.
  - in_ready = all 1s from the first cycle after RESET deasserts (0 while RESET is high).
  - out_data is don't-care while out_valid = 0.
- Reset asserted mid-operation discards all buffered flits immediately; no partial output.
- Route function on the FIFO head address A:
  - Slice s = A[ADDR_W-1-LEVEL*CB -: CB].
  - Prefix = A[ADDR_W-1 -: LEVEL*CB].
  - If LEVEL=0 or prefix == NODE_PREFIX, target = child s+1.
  - Otherwise target = parent (0).
  - If s >= NUM_CHILD (non-power-of-two child count), the flit is treated as a misroute.
- Drop rules, applied when the head is examined:
  - Target == own input port: pop the head, pulse err_uturn[p]; no output.
  - Input is the parent and target is the parent: pop the head, pulse err_misroute.
  - LEVEL=0 node whose child-input target is the parent: pop the head, pulse err_uturn[p]; the root parent output never asserts valid.
  - Drops take one cycle and do not request arbitration.
- Arbitration, per output o, every cycle:
  - Requesters = inputs with a non-empty FIFO whose head targets o.
  - Grant the first requester at or after ptr[o], cyclically.
  - On a grant, ptr[o] = winner+1 mod (NUM_CHILD+1).
  - A grant is issued only if output register o is empty, or is full with out_ready[o] high that cycle (full throughput, no bubble).
- Grant effect: pop the winner's FIFO; load output register o; out_valid[o] goes high next cycle.
- Latency: input handshake at edge t, head visible in cycle t+1, out_valid at t+2 when uncontended.
- Throughput: one flit per output per cycle. Different outputs are served in parallel, and different inputs may be granted to different outputs in the same cycle.
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO: allowed only if the pop is committed that cycle. in_ready is computed from the registered count, so no push is accepted when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Empty FIFO: no request.
- Flit order is preserved per (input, output) pair. No ordering is guaranteed across different inputs.

Decomposition:
- tree_router_pkg:
  - PARENT_PORT = 0 constant.
  - clog2-based CB function.
  - route_t typedef (target index, drop_uturn, drop_misroute).
  - Pure function route(addr, in_port, LEVEL, NODE_PREFIX).
- Sub-module rr_arbiter (N requesters; pointer register; grant one-hot; advance enable), instantiated once per output.
- The input FIFO stays inline as a generate loop.

Test Plan:
- NUM_CHILD=2, ADDR_W=4, LEVEL=1, NODE_PREFIX=1'b1: parent sends addr 4'b1100 -> appears on port 2 exactly 2 cycles after handshake; addr 4'b1000 -> port 1.
- Child 1 sends 4'b0011 -> port 0 (parent). Child 2 sends 4'b1100 -> dropped, err_uturn[2] pulses for 1 cycle, no out_valid anywhere.
- Parent sends 4'b0101 (prefix mismatch) -> err_misroute pulses; parent and child outputs stay idle.
- Both children stream to the parent continuously with out_ready=1 -> grants alternate 1,2,1,2; the parent output is valid every cycle.
- out_ready[2]=0 held for 6 cycles while the parent streams to child 2 -> the output holds, the parent FIFO fills, in_ready[0] drops after FIFO_DEPTH+1 accepted flits. On release, the flits drain in order with no loss or duplication.
- RESET pulsed asynchronously mid-stream with 3 flits buffered -> all out_valid drop immediately; no buffered flit emerges after reset; in_ready returns to 1s the cycle after release.

Source files
------------

// File: rtl/tree_router_pkg.sv
// Shared constants, route descriptor and the address-prefix route function
// for the fat-tree router node.
package tree_router_pkg;

    localparam int PARENT_PORT = 0;

    typedef struct packed {
        logic [7:0] target;
        logic       drop_uturn;
        logic       drop_misroute;
    } route_t;

    function automatic int cb_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Route decision for one head flit. Widths are passed explicitly so the
    // function is independent of any particular node's parameters.
    function automatic route_t route(
        input logic [31:0] addr,
        input logic [7:0]  in_port,
        input int          addr_w,
        input int          level,
        input int          cb,
        input int          num_child,
        input logic [31:0] node_prefix
    );
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] pre;
        logic [31:0] pmask;
        route_t      r;
        a     = addr & ((32'd1 << addr_w) - 32'd1);
        s     = (a >> (addr_w - (level + 1) * cb)) & ((32'd1 << cb) - 32'd1);
        pmask = (32'd1 << (level * cb)) - 32'd1;
        pre   = (a >> (addr_w - level * cb)) & pmask;
        r     = '0;
        if (s >= 32'(num_child)) begin
            // slice value names a child that does not exist
            r.target        = 8'(PARENT_PORT);
            r.drop_misroute = 1'b1;
        end else begin
            if ((level == 0) || (pre == (node_prefix & pmask))) begin
                r.target = 8'(s + 32'd1);
            end else begin
                r.target = 8'(PARENT_PORT);
            end
            if (r.target == in_port) begin
                if (in_port == 8'(PARENT_PORT)) begin
                    r.drop_misroute = 1'b1;
                end else begin
                    r.drop_uturn = 1'b1;
                end
            end else if ((level == 0) && (r.target == 8'(PARENT_PORT))) begin
                r.drop_uturn = 1'b1;
            end else begin
                r.drop_uturn = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tree_router_node_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner when the grant is enabled.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [N-1:0]  grant_s;
    logic          found_s;

    // Cyclic priority search: first pass from the pointer upward, then wrap.
    always_comb begin
        grant_s   = '0;
        ptr_nxt_s = ptr_r;
        found_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req[i] && (i >= int'(ptr_r))) begin
                found_s    = 1'b1;
                grant_s[i] = 1'b1;
                ptr_nxt_s  = (i == N - 1) ? '0 : PW'(i + 1);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_s && req[i] && (i < int'(ptr_r))) begin
                found_s    = 1'b1;
                grant_s[i] = 1'b1;
                ptr_nxt_s  = PW'(i + 1);
            end else begin
                found_s = found_s;
            end
        end
        if (!en) begin
            grant_s = '0;
            found_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
    end

    // Pointer register advances only on an issued grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/tree_router_node.sv
// Fat-tree router node: per-input FIFOs, prefix routing with U-turn/misroute
// drops, and a round-robin arbitrated registered stage per output.
module tree_router_node
    import tree_router_pkg::*;
#(
    parameter int NUM_CHILD   = 2,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int LEVEL       = 0,
    parameter int NODE_PREFIX = 0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [(NUM_CHILD+1)*DATA_W-1:0] in_data,
    input  logic [NUM_CHILD:0]              in_valid,
    output logic [NUM_CHILD:0]              in_ready,
    output logic [(NUM_CHILD+1)*DATA_W-1:0] out_data,
    output logic [NUM_CHILD:0]              out_valid,
    input  logic [NUM_CHILD:0]              out_ready,
    output logic [NUM_CHILD:0]              err_uturn,
    output logic                            err_misroute
);

    localparam int NP = NUM_CHILD + 1;
    localparam int CB = cb_of(NUM_CHILD);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic              rdy_en_r;
    logic [DATA_W-1:0] head_s [NP];
    route_t            rt_s   [NP];
    logic [NP-1:0]     nempty_s;
    logic [NP-1:0]     drop_s;
    logic [NP-1:0]     pop_s;
    logic [NP-1:0]     uturn_s;
    logic [NP-1:0]     mis_s;
    logic [NP-1:0]     out_en_s;
    logic [NP-1:0]     req_s  [NP];
    logic [NP-1:0]     gnt_s  [NP];
    logic [NP-1:0]     err_uturn_r;
    logic              err_misroute_r;

    // Holds in_ready low during reset and for the edge that releases it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_in
        logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
        logic [AW-1:0]     wptr_r;
        logic [AW-1:0]     rptr_r;
        logic [AW:0]       cnt_r;
        logic              push_s;

        // ready comes from the registered count, so a full FIFO never takes a push
        assign in_ready[p]  = rdy_en_r && (cnt_r != (AW+1)'(FIFO_DEPTH));
        assign push_s       = in_valid[p] && in_ready[p];
        assign nempty_s[p]  = (cnt_r != '0);
        assign head_s[p]    = mem_r[rptr_r];
        assign rt_s[p]      = route(32'(head_s[p][ADDR_W-1:0]), 8'(p), ADDR_W, LEVEL,
                                    CB, NUM_CHILD, 32'(NODE_PREFIX));

        // FIFO storage; contents are meaningless while the count is zero.
        always_ff @(posedge CLK) begin
            if (push_s) begin
                mem_r[wptr_r] <= in_data[p*DATA_W +: DATA_W];
            end else begin
                mem_r[wptr_r] <= mem_r[wptr_r];
            end
        end

        // FIFO pointers and occupancy.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wptr_r <= '0;
                rptr_r <= '0;
                cnt_r  <= '0;
            end else begin
                wptr_r <= push_s   ? wptr_r + 1'b1 : wptr_r;
                rptr_r <= pop_s[p] ? rptr_r + 1'b1 : rptr_r;
                cnt_r  <= cnt_r + (AW+1)'(push_s) - (AW+1)'(pop_s[p]);
            end
        end
    end

    // Classify each head: dropped in place, or requesting exactly one output.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            uturn_s[p] = nempty_s[p] && rt_s[p].drop_uturn;
            mis_s[p]   = nempty_s[p] && rt_s[p].drop_misroute;
            drop_s[p]  = uturn_s[p] || mis_s[p];
        end
        for (int o = 0; o < NP; o++) begin
            out_en_s[o] = !out_valid[o] || out_ready[o];
            for (int p = 0; p < NP; p++) begin
                req_s[o][p] = nempty_s[p] && !drop_s[p] && (rt_s[p].target == 8'(o));
            end
        end
    end

    // An input pops on a drop or when any output grants it.
    always_comb begin
        pop_s = drop_s;
        for (int o = 0; o < NP; o++) begin
            pop_s = pop_s | gnt_s[o];
        end
    end

    for (genvar o = 0; o < NP; o++) begin : g_out
        logic [DATA_W-1:0] mux_s;
        logic [DATA_W-1:0] data_r;
        logic              valid_r;

        rr_arbiter #(.N(NP)) u_arb (
            .clk   (CLK),
            .rst   (RESET),
            .req   (req_s[o]),
            .en    (out_en_s[o]),
            .grant (gnt_s[o])
        );

        // Winner's head flit selected by the one-hot grant.
        always_comb begin
            mux_s = '0;
            for (int p = 0; p < NP; p++) begin
                if (gnt_s[o][p]) begin
                    mux_s = mux_s | head_s[p];
                end else begin
                    mux_s = mux_s;
                end
            end
        end

        // Output register: loads on grant, empties when the flit is taken.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                valid_r <= 1'b0;
                data_r  <= '0;
            end else if (|gnt_s[o]) begin
                valid_r <= 1'b1;
                data_r  <= mux_s;
            end else if (out_ready[o]) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end

        assign out_valid[o]                  = valid_r;
        assign out_data[o*DATA_W +: DATA_W]  = data_r;
    end

    // Error pulses, one cycle per dropped head.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_uturn_r    <= '0;
            err_misroute_r <= 1'b0;
        end else begin
            err_uturn_r    <= uturn_s;
            err_misroute_r <= |mis_s;
        end
    end

    assign err_uturn    = err_uturn_r;
    assign err_misroute = err_misroute_r;

endmodule

// File: tb/tb_tree_router_node.sv
// Directed + random bench for tree_router_node (2 children, level 1, prefix 1),
// checked against a queue-based reference model of the routing rules.
module tb_tree_router_node;

    localparam int NP    = 3;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [47:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [47:0] out_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  err_uturn;
    logic        err_misroute;

    int n_checks;
    int n_fail;

    // reference model state
    logic [15:0] mq [NP][$];
    logic [15:0] acc_q [NP][$];
    bit          m_ov [NP];
    logic [15:0] m_od [NP];
    int          m_ptr [NP];
    logic [2:0]  m_eu;
    bit          m_em;
    bit          m_rdy;
    logic [2:0]  m_acc;

    bit          pv [NP];
    logic [15:0] pd [NP];

    tree_router_node #(
        .NUM_CHILD(2), .DATA_W(16), .ADDR_W(4), .LEVEL(1), .NODE_PREFIX(1), .FIFO_DEPTH(2)
    ) dut (
        .CLK(clk), .RESET(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_uturn(err_uturn), .err_misroute(err_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Destination port from address bits: bit3 = prefix, bit2 = child slice.
    function automatic int dest(input logic [15:0] f);
        int a;
        a = int'(f[3:0]);
        if (a / 8 == 1) return (a / 4) % 2 + 1;
        else return 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            m_ov[p]  = 1'b0;
            m_ptr[p] = 0;
        end
        m_eu  = 3'b000;
        m_em  = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic model_step();
        int          tgt [NP];
        bit          popd [NP];
        bit          nov [NP];
        logic [15:0] nod [NP];
        logic [2:0]  eu;
        bit          em;
        bit          found;
        int          base;
        int          c;
        eu = 3'b000;
        em = 1'b0;
        for (int p = 0; p < NP; p++) begin
            m_acc[p] = in_valid[p] && m_rdy && (mq[p].size() < DEPTH);
            popd[p]  = 1'b0;
            tgt[p]   = -1;
            if (mq[p].size() > 0) begin
                if (dest(mq[p][0]) == p) begin
                    popd[p] = 1'b1;
                    if (p == 0) em = 1'b1;
                    else eu[p] = 1'b1;
                end else begin
                    tgt[p] = dest(mq[p][0]);
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            nov[o] = m_ov[o] && !out_ready[o];
            nod[o] = m_od[o];
            found  = 1'b0;
            base   = m_ptr[o];
            if (!m_ov[o] || out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    c = (base + k) % NP;
                    if (!found && tgt[c] == o) begin
                        found    = 1'b1;
                        nov[o]   = 1'b1;
                        nod[o]   = mq[c][0];
                        popd[c]  = 1'b1;
                        m_ptr[o] = (c + 1) % NP;
                    end
                end
            end
        end
        for (int o = 0; o < NP; o++) begin
            m_ov[o] = nov[o];
            m_od[o] = nod[o];
        end
        for (int p = 0; p < NP; p++) begin
            if (popd[p]) void'(mq[p].pop_front());
            if (m_acc[p]) mq[p].push_back(in_data[p*16 +: 16]);
        end
        m_eu  = eu;
        m_em  = em;
        m_rdy = 1'b1;
    endtask

    task automatic check_all();
        logic [2:0] er;
        logic [2:0] ov;
        for (int p = 0; p < NP; p++) begin
            er[p] = m_rdy && (mq[p].size() < DEPTH);
            ov[p] = m_ov[p];
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ov));
        for (int o = 0; o < NP; o++) begin
            if (m_ov[o]) chk("out_data", 32'(out_data[o*16 +: 16]), 32'(m_od[o]));
        end
        chk("err_uturn", 32'(err_uturn), 32'(m_eu));
        chk("err_misroute", 32'(err_misroute), 32'(m_em));
    endtask

    // One cycle: compare against the model, drive inputs, advance the model.
    task automatic step(input logic [2:0] iv, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [2:0] ordy);
        check_all();
        in_valid  = iv;
        in_data   = {d2, d1, d0};
        out_ready = ordy;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        step(3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b111);
    endtask

    // Cycle driven from the pending-flit registers; accepted flits are logged.
    task automatic cyc(input logic [2:0] ordy);
        step({pv[2], pv[1], pv[0]}, pd[0], pd[1], pd[2], ordy);
        for (int p = 0; p < NP; p++) begin
            if (m_acc[p]) begin
                acc_q[p].push_back(pd[p]);
                pv[p] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_tag;
        logic [2:0] ordy;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 3'b000;
        in_data   = 48'h0;
        out_ready = 3'b111;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0;
            pd[p] = 16'h0000;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(3'b000));
        chk("rst_out_valid", 32'(out_valid), 32'(3'b000));
        chk("rst_err", 32'({err_uturn, err_misroute}), 32'(4'b0000));
        rst = 1'b0;
        idle();
        chk("ready_after_rst", 32'(in_ready), 32'(3'b111));

        // parent -> child 2, two-cycle latency
        step(3'b001, 16'hA00C, 16'h0000, 16'h0000, 3'b111);
        chk("lat_head_cycle", 32'(out_valid), 32'(3'b000));
        idle();
        chk("lat_valid", 32'(out_valid), 32'(3'b100));
        chk("lat_data", 32'(out_data[47:32]), 32'(16'hA00C));
        // parent -> child 1
        step(3'b001, 16'hB008, 16'h0000, 16'h0000, 3'b111);
        idle();
        chk("child1_valid", 32'(out_valid), 32'(3'b010));
        chk("child1_data", 32'(out_data[31:16]), 32'(16'hB008));
        // child 1 -> parent
        step(3'b010, 16'h0000, 16'hC003, 16'h0000, 3'b111);
        idle();
        chk("parent_valid", 32'(out_valid), 32'(3'b001));
        chk("parent_data", 32'(out_data[15:0]), 32'(16'hC003));
        // child 2 U-turn
        step(3'b100, 16'h0000, 16'h0000, 16'hD00C, 3'b111);
        idle();
        chk("uturn_pulse", 32'(err_uturn), 32'(3'b100));
        chk("uturn_no_out", 32'(out_valid), 32'(3'b000));
        idle();
        chk("uturn_one_cycle", 32'(err_uturn), 32'(3'b000));
        // parent prefix mismatch
        step(3'b001, 16'hE005, 16'h0000, 16'h0000, 3'b111);
        idle();
        chk("misroute_pulse", 32'(err_misroute), 32'(1'b1));
        chk("misroute_no_out", 32'(out_valid), 32'(3'b000));
        idle();
        chk("misroute_one_cycle", 32'(err_misroute), 32'(1'b0));

        // both children stream to the parent; parent pointer sits at child 2
        exp_tag = 4'h2;
        for (int n = 0; n < 14; n++) begin
            if (!pv[1]) begin pv[1] = 1'b1; pd[1] = {4'h1, 8'(n), 4'h3}; end
            if (!pv[2]) begin pv[2] = 1'b1; pd[2] = {4'h2, 8'(n), 4'h3}; end
            cyc(3'b111);
            if (n >= 1) begin
                chk("rr_parent_busy", 32'(out_valid[0]), 32'(1'b1));
                chk("rr_alternate", 32'(out_data[15:12]), 32'(exp_tag));
                exp_tag = (exp_tag == 4'h2) ? 4'h1 : 4'h2;
            end
        end
        repeat (12) cyc(3'b111);

        // backpressure on child 2 while the parent streams to it
        for (int p = 0; p < NP; p++) acc_q[p].delete();
        for (int n = 0; n < 6; n++) begin
            if (!pv[0]) begin pv[0] = 1'b1; pd[0] = {4'h5, 8'(n), 4'hC}; end
            cyc(3'b011);
        end
        chk("bp_accepted", 32'(acc_q[0].size()), 32'(DEPTH + 1));
        chk("bp_in_ready_low", 32'(in_ready[0]), 32'(1'b0));
        chk("bp_hold_valid", 32'(out_valid[2]), 32'(1'b1));
        chk("bp_hold_data", 32'(out_data[47:32]), 32'(acc_q[0][0]));
        for (int n = 0; n < 10; n++) begin
            if (out_valid[2]) begin
                chk("drain_no_extra", 32'(acc_q[0].size() > 0), 32'(1'b1));
                if (acc_q[0].size() > 0) chk("drain_order", 32'(out_data[47:32]), 32'(acc_q[0].pop_front()));
            end
            cyc(3'b111);
        end
        chk("drain_complete", 32'(acc_q[0].size()), 32'(0));

        // asynchronous reset with flits buffered
        for (int n = 0; n < 4; n++) begin
            if (!pv[0]) begin pv[0] = 1'b1; pd[0] = {4'h6, 8'(n), 4'hC}; end
            cyc(3'b011);
        end
        chk("pre_rst_buffered", 32'(out_valid[2]), 32'(1'b1));
        for (int p = 0; p < NP; p++) pv[p] = 1'b0;
        in_valid = 3'b000;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'(3'b000));
        chk("rst_mid_in_ready", 32'(in_ready), 32'(3'b000));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("ready_after_release", 32'(in_ready), 32'(3'b111));
        for (int n = 0; n < 4; n++) begin
            idle();
            chk("no_ghost_flit", 32'(out_valid), 32'(3'b000));
        end

        // random traffic against the model
        for (int p = 0; p < NP; p++) acc_q[p].delete();
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] && ($urandom_range(1, 0) == 1)) begin
                    pv[p] = 1'b1;
                    pd[p] = {4'(p), 8'(n), 4'($urandom_range(15, 0))};
                end
            end
            ordy = 3'($urandom) | 3'($urandom);
            cyc(ordy);
        end
        repeat (12) cyc(3'b111);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
